// File: rtl/seq_code_puncturer.sv
// seq_code_puncturer
// Rate-matching stage after the convolutional encoder. Deletes parity bits
// according to the code rate (1/2, 3/4, 7/8), repacks the surviving bit
// stream into 2-bit symbols, tracks frame boundaries and pads the final odd
// bit of a frame with a zero in a dedicated flush cycle.

module seq_code_puncturer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_code_rate,
    input  logic       i_vld,
    input  logic [1:0] i_data,
    input  logic       i_sof,
    input  logic       i_eof,
    output logic       o_vld,
    output logic [1:0] o_data,
    output logic       o_sof,
    output logic       o_eof,
    output logic       o_err
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t     state;

    // Rate held as K-1 (0, 2 or 6) so the keep test is a single compare.
    logic [2:0] rate_km1;
    logic [2:0] ph;

    // One-bit leftover buffer between pairs.
    logic       hold_v;
    logic       hold_b;

    // An i_sof pair was seen but has not yet produced a symbol.
    logic       sof_pend;

    // Per-pair combinational results.
    logic [2:0] pair_ph;
    logic       keep;
    logic       eff_hold;
    logic       sof_err;
    logic       emit;
    logic [1:0] emit_sym;
    logic       nxt_hold_v;
    logic       nxt_hold_b;
    logic [2:0] nxt_ph;
    logic [2:0] rate_km1_dec;

    // Decode the code-rate input into K-1; code 3 aliases rate 1/2.
    always_comb begin
        rate_km1_dec = 3'd0;
        case (i_code_rate)
            2'd1:    rate_km1_dec = 3'd2;
            2'd2:    rate_km1_dec = 3'd6;
            default: rate_km1_dec = 3'd0;
        endcase
    end

    // Work out how the incoming pair merges with the leftover bit.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        pair_ph    = ph;
        keep       = 1'b0;
        eff_hold   = 1'b0;
        sof_err    = 1'b0;
        emit       = 1'b0;
        emit_sym   = 2'b00;
        nxt_hold_v = hold_v;
        nxt_hold_b = hold_b;
        nxt_ph     = ph;

        // A start-of-frame pair always restarts the puncturing pattern.
        if (i_sof) begin
            pair_ph = 3'd0;
        end

        keep   = (pair_ph == rate_km1);
        nxt_ph = keep ? 3'd0 : pair_ph + 3'd1;

        // A leftover bit from before an i_sof belongs to a broken frame.
        sof_err  = i_sof && hold_v;
        eff_hold = hold_v && !i_sof;

        emit = eff_hold || keep;

        if (eff_hold) begin
            // Leftover + systematic form the symbol; a kept parity waits.
            emit_sym   = {hold_b, i_data[1]};
            nxt_hold_v = keep;
            nxt_hold_b = i_data[0];
        end else if (keep) begin
            // Systematic + kept parity form the symbol directly.
            emit_sym   = i_data;
            nxt_hold_v = 1'b0;
            nxt_hold_b = 1'b0;
        end else begin
            // Lone systematic bit becomes the leftover.
            emit_sym   = 2'b00;
            nxt_hold_v = 1'b1;
            nxt_hold_b = i_data[1];
        end
    end

    // Frame FSM, bit buffer, phase counter and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples the values from before this clock edge.
        if (!reset_n) begin
            state    <= ST_RUN;
            rate_km1 <= rate_km1_dec;
            ph       <= 3'd0;
            hold_v   <= 1'b0;
            hold_b   <= 1'b0;
            sof_pend <= 1'b0;
            o_vld    <= 1'b0;
            o_data   <= 2'b00;
            o_sof    <= 1'b0;
            o_eof    <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_vld  <= 1'b0;
            o_data <= 2'b00;
            o_sof  <= 1'b0;
            o_eof  <= 1'b0;
            o_err  <= 1'b0;

            case (state)
                ST_RUN: begin
                    if (i_vld) begin
                        o_err    <= sof_err;
                        o_vld    <= emit;
                        o_data   <= emit_sym;
                        o_sof    <= emit && (i_sof || sof_pend);
                        // The end marker waits for the pad if a bit is left.
                        o_eof    <= emit && i_eof && !nxt_hold_v;
                        hold_v   <= nxt_hold_v;
                        hold_b   <= nxt_hold_b;
                        ph       <= nxt_ph;
                        sof_pend <= emit ? 1'b0 : (i_sof || sof_pend);
                        if (i_eof && nxt_hold_v) begin
                            state <= ST_FLUSH;
                        end
                    end
                end

                ST_FLUSH: begin
                    // Pad the odd final bit with a zero and close the frame;
                    // any pair arriving now violates the frame gap.
                    o_vld    <= 1'b1;
                    o_data   <= {hold_b, 1'b0};
                    o_sof    <= sof_pend;
                    o_eof    <= 1'b1;
                    o_err    <= i_vld;
                    hold_v   <= 1'b0;
                    hold_b   <= 1'b0;
                    ph       <= 3'd0;
                    sof_pend <= 1'b0;
                    state    <= ST_RUN;
                end

                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
